lane_fifo: RTL
==============

# lane_fifo

Parametrised synchronous FIFO for the PCIe transmit-layer lane datapath. It generalises the per-lane FIFOs with configurable depth and width, programmable almost-full/almost-empty margins, and guarded write/read. Overflow and underflow are detected, and sticky error flags record them. It has a registered read port with a valid strobe and a selectable idle-output mode. It sits between the upstream packet/byte source and the lane arbiter, one instance per lane.

## Interface
Parameters:
- DATA_WIDTH, 6, word width
- ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH
- AF_MARGIN, 1, almost_full asserts when count >= DEPTH - AF_MARGIN
- AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN
- ZERO_IDLE, 1, 1: data_out driven to 0 on cycles without an accepted read; 0: data_out holds its last value

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_enable  in  1  write request
- rd_enable  in  1  read request
- data_in  in  DATA_WIDTH  write data
- err_clr  in  1  synchronous clear of the sticky overflow/underflow flags
- data_out  out  DATA_WIDTH  registered read data
- valid_out  out  1  data_out carries a popped word this cycle
- full_fifo  out  1  count == DEPTH
- empty_fifo  out  1  count == 0
- almost_full_fifo  out  1  see AF_MARGIN
- almost_empty_fifo  out  1  see AE_MARGIN (includes count 0)
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was rejected
- error  out  1  overflow | underflow
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

## Operation
- Write acceptance: wr_acc = wr_enable & (~full | rd_enable). Read acceptance: rd_acc = rd_enable & ~empty.
- On wr_acc: mem[wr_ptr] <= data_in, wr_ptr increments and wraps modulo DEPTH.
- On rd_acc: data_out <= mem[rd_ptr], valid_out <= 1, and rd_ptr increments and wraps.
- Without rd_acc: valid_out <= 0. data_out goes to 0 if ZERO_IDLE=1; otherwise it holds.
- The count register updates by +wr_acc −rd_acc and never leaves 0..DEPTH.
- When full, a simultaneous write and read are both accepted; the count stays at DEPTH and the read returns the oldest word.
- When empty, a simultaneous write and read accept the write only. The read is rejected, underflow is set, and the count goes to 1. There is no fall-through.
- Write while full with no read: the write is dropped, overflow <= 1, and memory and pointers are unchanged.
- Read while empty: underflow <= 1 and valid_out <= 0.
- Sticky flags hold until err_clr or reset. If err_clr coincides with a new violation in the same cycle, the flag is set.
- All status flags are combinational from the count register only, never from the current-cycle enables.

## Timing
- Reset (async assert, deasserted synchronously by the system) clears wr_ptr, rd_ptr, count, data_out, valid_out, overflow and underflow to 0.
- Values during and after reset: empty_fifo=1, almost_empty_fifo=1 (with AE_MARGIN≥0), full_fifo=0, almost_full_fifo=0 (when AF_MARGIN<DEPTH), error=0. Memory contents are not reset.
- Read latency: data and valid_out appear 1 cycle after the rd_enable edge.
- Flag and fifo_count latency: they reflect the enables 1 cycle after the edge.
- A reset asserted mid-operation discards all contents immediately. Outputs take their reset values without waiting for a clock.

## Structure
- A shared package/include (lane_fifo_pkg) holds the default widths, depth localparam, and the count-width function (clog2-style).
- The natural sub-module is lane_fifo_mem: a DEPTH×DATA_WIDTH register array with one write port and one registered read port.
- Pointer, count, flag and error logic stay in lane_fifo.
- Parameter checks at elaboration: AF_MARGIN < DEPTH and AE_MARGIN < DEPTH.

## Test plan
- Reset, then write 0x01,0x02,0x03,0x04 on consecutive cycles (DEPTH=4) -> full_fifo=1, fifo_count=4; almost_full asserts at count 3; error stays 0.
- Issue a 5th write of 0x3F while full -> it is dropped, overflow=1, count=4. Then read 4 words -> 0x01..0x04, each 1 cycle after its rd_enable, with valid_out=1.
- From empty, issue rd_enable -> valid_out=0, data_out=0 (ZERO_IDLE=1), underflow=1. Pulse err_clr -> underflow=0 on the next cycle.
- While full, issue simultaneous wr 0x2A and rd -> the read returns the oldest word and count stays 4. Keep streaming DEPTH*3 cycles -> verify pointer wrap and FIFO order against a scoreboard.
- When empty, issue simultaneous wr 0x15 and rd -> count=1, underflow=1, valid_out=0. The next read returns 0x15.
- Assert reset asynchronously mid-stream with count=3 -> all outputs reach reset values before the next edge. After release, the first read on empty flags underflow.

Source files
------------

// File: rtl/lane_fifo_pkg.sv
// Shared defaults and sizing helpers for the per-lane transmit FIFO.
// Pure declarations, no logic or latency.
// No flow control here; consumers apply their own handshakes.
package lane_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
    localparam int DEF_AF_MARGIN  = 1;
    localparam int DEF_AE_MARGIN  = 1;
    localparam bit DEF_ZERO_IDLE  = 1'b1;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lane_fifo_mem.sv
// DEPTH x DATA_WIDTH register array, one write port, one registered read port.
// Read data appears one cycle after rd_en; idle cycles give 0 or hold per ZERO_IDLE.
// No backpressure; the caller guarantees legal addresses and enables.
module lane_fifo_mem
    import lane_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_IDLE  = DEF_ZERO_IDLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else if (ZERO_IDLE) begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO with margins, sticky overflow/underflow and registered read.
// Read data/valid one cycle after rd_enable; flags and count one cycle after the enables.
// Writes while full are dropped unless a read is accepted in the same cycle; reads while empty are rejected.
module lane_fifo
    import lane_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_MARGIN  = DEF_AF_MARGIN,
    parameter int AE_MARGIN  = DEF_AE_MARGIN,
    parameter bit ZERO_IDLE  = DEF_ZERO_IDLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   fifo_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_TH   = CW'(AE_MARGIN);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    if (AF_MARGIN >= DEPTH || AF_MARGIN < 0) begin : g_bad_af
        $error("lane_fifo: AF_MARGIN must be in 0..DEPTH-1");
    end
    if (AE_MARGIN >= DEPTH || AE_MARGIN < 0) begin : g_bad_ae
        $error("lane_fifo: AE_MARGIN must be in 0..DEPTH-1");
    end
    if (count_width(DEPTH) != CW) begin : g_bad_cw
        $error("lane_fifo: count width mismatch");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  unf_evt;

    // Status flags derive from the count register only.
    assign full_fifo         = (count == DEPTH_C);
    assign empty_fifo        = (count == '0);
    assign almost_full_fifo  = (count >= AF_TH);
    assign almost_empty_fifo = (count <= AE_TH);
    assign fifo_count        = count;
    assign error             = overflow | underflow;

    // A read frees a slot in the same cycle, so full+read still accepts the write.
    assign wr_acc  = wr_enable & (~full_fifo | rd_enable);
    assign rd_acc  = rd_enable & ~empty_fifo;
    assign ovf_evt = wr_enable & ~wr_acc;
    assign unf_evt = rd_enable & ~rd_acc;

    lane_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_IDLE  (ZERO_IDLE)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    // Pointers advance on acceptance and wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks +wr_acc -rd_acc; acceptance rules keep it in 0..DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // Read valid strobe aligned with the registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_acc;
        end
    end

    // Sticky error flags; a new violation wins over a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (unf_evt)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

endmodule
